// File: rtl/block_sf_48_dematrix.sv
// rtl/block_sf_48_dematrix.sv - stereo sum/difference de-matrix with pairing FSM; DEMATRIX_SAT_EN selects clamping over wrap
module block_sf_48_dematrix #(
    parameter int W  = 18,
    parameter int GW = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] LI_in_LpR,
    input  logic                ready_in_LpR,
    input  logic signed [W-1:0] LI_in_LmR,
    input  logic                ready_in_LmR,
    input  logic [GW-1:0]       Gs,
    input  logic [GW-1:0]       Gd,
    output logic signed [W-1:0] LEFT,
    output logic signed [W-1:0] RIGHT,
    output logic                ready_out,
    output logic                overrun
);

    // Product of a sample and a zero-extended gain, scaled S/D, and the L/R sums
    localparam int PW = W + GW + 1;
    localparam int SW = W + 1;
    localparam int AW = W + 2;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        HAVE_LPR = 2'd1,
        HAVE_LMR = 2'd2
    } pair_state_t;

    pair_state_t        state;
    pair_state_t        state_next;
    logic signed [W-1:0] held_lpr;
    logic signed [W-1:0] held_lmr;
    logic signed [W-1:0] held_lpr_next;
    logic signed [W-1:0] held_lmr_next;
    logic signed [W-1:0] pair_lpr;
    logic signed [W-1:0] pair_lmr;
    logic                fire;
    logic                ovr_set;

    logic                s0_valid;
    logic signed [W-1:0] s0_lpr;
    logic signed [W-1:0] s0_lmr;
    logic [GW-1:0]       s0_gs;
    logic [GW-1:0]       s0_gd;

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] rnd_s;
    logic signed [PW-1:0] rnd_d;

    logic                 s1_valid;
    logic signed [SW-1:0] s1_s;
    logic signed [SW-1:0] s1_d;

    logic signed [AW-1:0] sum_l;
    logic signed [AW-1:0] sum_r;
    logic signed [SW-1:0] half_l;
    logic signed [SW-1:0] half_r;
    logic [W-1:0]         left_next;
    logic [W-1:0]         right_next;

    logic                 unused_bits;

    // Pair state, held samples and the sticky overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= EMPTY;
            held_lpr <= '0;
            held_lmr <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            held_lpr <= held_lpr_next;
            held_lmr <= held_lmr_next;
            overrun  <= overrun | ovr_set;
        end
    end

    // Pairing decisions: a held sample always pairs with the first opposite strobe
    always_comb begin
        state_next    = state;
        held_lpr_next = held_lpr;
        held_lmr_next = held_lmr;
        pair_lpr      = LI_in_LpR;
        pair_lmr      = LI_in_LmR;
        fire          = 1'b0;
        ovr_set       = 1'b0;
        case (state)
            EMPTY: begin
                if (ready_in_LpR && ready_in_LmR) begin
                    fire = 1'b1;
                end else if (ready_in_LpR) begin
                    held_lpr_next = LI_in_LpR;
                    state_next    = HAVE_LPR;
                end else if (ready_in_LmR) begin
                    held_lmr_next = LI_in_LmR;
                    state_next    = HAVE_LMR;
                end
            end
            HAVE_LPR: begin
                pair_lpr = held_lpr;
                if (ready_in_LmR) begin
                    fire = 1'b1;
                    if (ready_in_LpR) begin
                        held_lpr_next = LI_in_LpR;
                    end else begin
                        state_next = EMPTY;
                    end
                end else if (ready_in_LpR) begin
                    held_lpr_next = LI_in_LpR;
                    ovr_set       = 1'b1;
                end
            end
            HAVE_LMR: begin
                pair_lmr = held_lmr;
                if (ready_in_LpR) begin
                    fire = 1'b1;
                    if (ready_in_LmR) begin
                        held_lmr_next = LI_in_LmR;
                    end else begin
                        state_next = EMPTY;
                    end
                end else if (ready_in_LmR) begin
                    held_lmr_next = LI_in_LmR;
                    ovr_set       = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Stage 0: capture the completed pair together with the gains in force
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= fire;
            if (fire) begin
                s0_lpr <= pair_lpr;
                s0_lmr <= pair_lmr;
                s0_gs  <= Gs;
                s0_gd  <= Gd;
            end
        end
    end

    // Gains are Q1.3: multiply, add half an LSB, keep bits above the 3 fraction bits
    assign prod_s = PW'(s0_lpr) * $signed(PW'({1'b0, s0_gs}));
    assign prod_d = PW'(s0_lmr) * $signed(PW'({1'b0, s0_gd}));
    assign rnd_s  = prod_s + PW'(4);
    assign rnd_d  = prod_d + PW'(4);

    // Stage 1: register the scaled sum and difference signals
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_s <= rnd_s[SW+2:3];
                s1_d <= rnd_d[SW+2:3];
            end
        end
    end

    // Half of (S +/- D) rounded toward +inf; dropping bit 0 is the arithmetic shift
    assign sum_l  = AW'(s1_s) + AW'(s1_d) + AW'(1);
    assign sum_r  = AW'(s1_s) - AW'(s1_d) + AW'(1);
    assign half_l = sum_l[AW-1:1];
    assign half_r = sum_r[AW-1:1];

    // Narrow the halves to W bits: clamp when the top two bits disagree, else wrap
    always_comb begin
        left_next  = half_l[W-1:0];
        right_next = half_r[W-1:0];
`ifdef DEMATRIX_SAT_EN
        if (half_l[SW-1] != half_l[SW-2]) begin
            left_next = half_l[SW-1] ? MIN_NEG : MAX_POS;
        end
        if (half_r[SW-1] != half_r[SW-2]) begin
            right_next = half_r[SW-1] ? MIN_NEG : MAX_POS;
        end
`else
        if (1'b0) begin
            left_next  = MAX_POS;
            right_next = MIN_NEG;
        end
`endif
    end

    // Stage 2: output registers hold their value until the next valid result
    always_ff @(posedge clock) begin
        if (reset) begin
            LEFT      <= '0;
            RIGHT     <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= s1_valid;
            if (s1_valid) begin
                LEFT  <= left_next;
                RIGHT <= right_next;
            end
        end
    end

    assign unused_bits = ^{rnd_s[PW-1:SW+3], rnd_s[2:0], rnd_d[PW-1:SW+3], rnd_d[2:0],
                           sum_l[0], sum_r[0], half_l[SW-1], half_r[SW-1]};

endmodule
